seq_adder_n: RTL and testbench
==============================

# seq_adder_n

Parametrised multi-cycle adder/subtractor that generalises the team's 4-bit ripple adder to any operand width. It processes CHUNK bits per clock and carries between chunks in a register, trading latency for a narrow carry chain. A start/busy/done handshake lets a controller issue operations back-to-back. It sits beside the combinational adders in the datapath wherever timing closure needs a short carry path.

## Interface

- WIDTH, 16, operand/result width; must be a positive multiple of CHUNK
- CHUNK, 4, bits added per clock; N = WIDTH/CHUNK cycles per operation
- clk_in  input  1  clock, all state updates on rising edge
- rst_n_in  input  1  asynchronous, active-low reset
- start_in  input  1  request; sampled only when not busy
- sub_in  input  1  0 = add, 1 = subtract; captured with start
- a_in  input  WIDTH  augend / minuend; captured with start
- b_in  input  WIDTH  addend / subtrahend; captured with start
- c_in  input  1  carry-in (add) or borrow-in (subtract); captured with start
- sum_out  output  WIDTH  result, held until next completion
- carry_out  output  1  raw carry from MSB (subtract: 1 = no borrow)
- overflow_out  output  1  two's-complement signed overflow
- busy_out  output  1  operation in progress
- done_out  output  1  one-cycle pulse: new result valid

## Operation

- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE or DONE with start_in=1: capture a_in, b_in, sub_in, c_in. Go to RUN with chunk index 0.
- Effective operand: b_eff = sub ? ~b : b. Effective carry-in: c_eff = c_in XOR sub_in.
  - Add: result = a + b + c_in.
  - Subtract: result = a - b - c_in.
- RUN: each cycle adds chunk i of a and b_eff plus the carry register. The CHUNK-bit sum goes into an internal result shift register. The carry register takes the chunk carry. The index increments.
- Last chunk (i = N-1):
  - sum_out gets the full result; carry_out gets the final carry.
  - overflow_out = carry into MSB XOR carry out of MSB.
  - State goes to DONE.
- DONE lasts one cycle: done_out=1. Next state is RUN if start_in=1, else IDLE.
- start_in in RUN is ignored; no queueing.
- sum_out, carry_out and overflow_out change only on completion. Internal partial sums are never visible.
- Input changes after the capture edge do not affect the operation in flight.

## Timing

- Reset: sum_out=0, carry_out=0, overflow_out=0, busy_out=0, done_out=0, state IDLE, index 0, carry register 0.
- Reset asserted mid-RUN: the operation is aborted with no result; all outputs return to reset values immediately.
- Start captured at edge T:
  - busy_out=1 in cycles T+1 … T+N.
  - Results update at edge T+N.
  - done_out=1 and busy_out=0 in the cycle after edge T+N.
- Latency from start edge to done_out = N cycles. Back-to-back throughput = one result per N+1 cycles.
- CHUNK=WIDTH (N=1): one RUN cycle, then done_out.
- busy_out and done_out are never high together. done_out is exactly one cycle wide.

## Test plan

- WIDTH=16, CHUNK=4, add a=0x1234 b=0x4321 c=0 -> sum 0x5555, carry 0, overflow 0; done_out high exactly 4 cycles after the start edge; busy high for 4 cycles.
- Add a=0xFFFF b=0x0001 c=0 -> sum 0x0000, carry 1, overflow 0. Add a=0x7FFF b=0x0001 c=0 -> sum 0x8000, carry 0, overflow 1.
- Subtract a=0x0005 b=0x0007 c=0 -> sum 0xFFFE, carry 0. Subtract a=0x8000 b=0x0001 c=0 -> sum 0x7FFF, overflow 1. Subtract a=0x0010 b=0x0001 c=1 -> sum 0x000E, carry 1.
- start_in held high and operands changed every cycle during RUN:
  - the result matches the operands captured at the first start;
  - the second operation starts from DONE;
  - done pulses are 5 cycles apart.
- Reset at RUN cycle 2:
  - all outputs are 0 immediately and no done_out follows;
  - a new start after reset completes correctly.
- Sweep CHUNK ∈ {1, 4, 16} with WIDTH=16: random operands against a reference model; latency = 16/4/1 cycles respectively.

Source files
------------

// File: rtl/seq_adder_n.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock with a registered
// carry between chunks, so the carry chain is only CHUNK bits long.
module seq_adder_n #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic             sub_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             overflow_out,
  output logic             busy_out,
  output logic             done_out
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [CHUNK-1:0]   a_chunk [N];
  logic [CHUNK-1:0]   b_chunk [N];
  logic [CHUNK-1:0]   a_cur, b_cur;
  logic [CHUNK:0]     chunk_sum;
  logic               c_msb_in;
  logic               last;

  // b_q already holds the effective (possibly inverted) operand.
  for (genvar gi = 0; gi < N; gi++) begin : g_chunk
    assign a_chunk[gi] = a_q[gi*CHUNK +: CHUNK];
    assign b_chunk[gi] = b_q[gi*CHUNK +: CHUNK];
  end

  always_comb begin
    a_cur = '0;
    b_cur = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_cur = a_chunk[i];
        b_cur = b_chunk[i];
      end
    end
  end

  assign chunk_sum = {1'b0, a_cur} + {1'b0, b_cur} + {{CHUNK{1'b0}}, carry_q};
  // Sum bit = a ^ b ^ cin, so the carry into the MSB falls out of the sum bit.
  assign c_msb_in  = chunk_sum[CHUNK-1] ^ a_cur[CHUNK-1] ^ b_cur[CHUNK-1];
  assign last      = (idx_q == IDX_W'(N - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start_in) begin
          a_d     = a_in;
          b_d     = sub_in ? ~b_in : b_in;
          carry_d = c_in ^ sub_in;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < N; i++) begin
          if (idx_q == IDX_W'(i)) res_d[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        end
        carry_d = chunk_sum[CHUNK];
        idx_d   = idx_q + 1'b1;
        if (last) begin
          sum_d   = res_d;
          cout_d  = chunk_sum[CHUNK];
          ovf_d   = c_msb_in ^ chunk_sum[CHUNK];
          idx_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum_out      = sum_q;
  assign carry_out    = cout_q;
  assign overflow_out = ovf_q;
  assign busy_out     = (state_q == RUN);
  assign done_out     = (state_q == DONE);

endmodule

// File: tb/tb_seq_adder_n.sv
// Directed bench for seq_adder_n: three instances (CHUNK 1/4/16, WIDTH 16)
// share stimulus; results, latency, handshake and reset abort are checked.
module tb_seq_adder_n;

  logic        clk;
  logic        rst_n, start, sub, c;
  logic [15:0] a, b;
  logic [15:0] sum_w  [3];
  logic        carry_w[3], ovf_w[3], busy_w[3], done_w[3];

  int n_checks = 0;
  int n_fail   = 0;
  int overlap  = 0;
  int ncyc  [3] = '{16, 4, 1};
  int chunks[3] = '{1, 4, 16};
  int lat   [3];
  int bcnt  [3];
  int dcnt  [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seq_adder_n #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .sub_in(sub),
    .a_in(a), .b_in(b), .c_in(c), .sum_out(sum_w[0]), .carry_out(carry_w[0]),
    .overflow_out(ovf_w[0]), .busy_out(busy_w[0]), .done_out(done_w[0]));

  seq_adder_n #(.WIDTH(16), .CHUNK(4)) u_c4 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .sub_in(sub),
    .a_in(a), .b_in(b), .c_in(c), .sum_out(sum_w[1]), .carry_out(carry_w[1]),
    .overflow_out(ovf_w[1]), .busy_out(busy_w[1]), .done_out(done_w[1]));

  seq_adder_n #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .sub_in(sub),
    .a_in(a), .b_in(b), .c_in(c), .sum_out(sum_w[2]), .carry_out(carry_w[2]),
    .overflow_out(ovf_w[2]), .busy_out(busy_w[2]), .done_out(done_w[2]));

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) if (busy_w[k] && done_w[k]) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {overflow, carry, sum} of a +/- b with carry/borrow in.
  function automatic logic [17:0] model(input logic [15:0] ma, mb, input logic ms, mc);
    logic [15:0] be;
    logic [16:0] full;
    logic        ov;
    be   = ms ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, be} + {16'd0, mc ^ ms};
    ov   = (ma[15] == be[15]) && (full[15] != ma[15]);
    return {ov, full};
  endfunction

  task automatic run_op(input logic [15:0] ta, tb, input logic ts, tc);
    @(negedge clk);
    a = ta; b = tb; sub = ts; c = tc; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      lat[k] = -1; bcnt[k] = 0; dcnt[k] = 0;
    end
    for (int e = 0; e < 24; e++) begin
      if (e > 0) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (busy_w[k]) bcnt[k]++;
        if (done_w[k]) begin
          dcnt[k]++;
          if (lat[k] < 0) lat[k] = e;
        end
      end
    end
  endtask

  task automatic check_op(input string name, input logic [15:0] es, input logic ec, eo);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s c%0d sum", name, chunks[k]), 32'(sum_w[k]), 32'(es));
      check($sformatf("%s c%0d carry", name, chunks[k]), 32'(carry_w[k]), 32'(ec));
      check($sformatf("%s c%0d ovf", name, chunks[k]), 32'(ovf_w[k]), 32'(eo));
      check($sformatf("%s c%0d latency", name, chunks[k]), 32'(lat[k]), 32'(ncyc[k]));
      check($sformatf("%s c%0d busy_cycles", name, chunks[k]), 32'(bcnt[k]), 32'(ncyc[k]));
      check($sformatf("%s c%0d done_pulses", name, chunks[k]), 32'(dcnt[k]), 32'd1);
    end
  endtask

  typedef struct {
    logic [15:0] va, vb;
    logic        vs, vc;
    logic [15:0] es;
    logic        ec, eo;
  } vec_t;

  vec_t vecs[6] = '{
    '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0},
    '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
    '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
    '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0},
    '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1},
    '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0}
  };

  initial begin
    int          d1, d2, dones;
    logic [15:0] r1;
    logic [17:0] m;
    logic [15:0] ra, rb;
    logic        rs, rc;

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; c = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset c%0d sum", chunks[k]), 32'(sum_w[k]), 32'd0);
      check($sformatf("reset c%0d busy", chunks[k]), 32'(busy_w[k]), 32'd0);
      check($sformatf("reset c%0d done", chunks[k]), 32'(done_w[k]), 32'd0);
    end
    check("reset carry", 32'(carry_w[1]), 32'd0);
    check("reset ovf", 32'(ovf_w[1]), 32'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      run_op(vecs[v].va, vecs[v].vb, vecs[v].vs, vecs[v].vc);
      check_op($sformatf("vec%0d", v), vecs[v].es, vecs[v].ec, vecs[v].eo);
    end

    // start held high, operands scrambled each cycle; CHUNK=4 instance judged.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; sub = 1'b0; c = 1'b0; start = 1'b1;
    @(posedge clk);
    d1 = -1; d2 = -1; dones = 0; r1 = '0;
    for (int e = 0; e < 15; e++) begin
      if (e > 0) @(posedge clk);
      #1;
      if (e == 4) begin
        a = 16'h0F0F; b = 16'h0101; sub = 1'b0; c = 1'b0;
      end else begin
        a = 16'hA5A5 ^ 16'(e * 16'h1357); b = 16'h5A5A + 16'(e); sub = e[0]; c = e[1];
      end
      if (e >= 5) start = 1'b0;
      @(negedge clk);
      if (done_w[1]) begin
        dones++;
        if (d1 < 0) begin
          d1 = e; r1 = sum_w[1];
        end else if (d2 < 0) d2 = e;
      end
    end
    check("b2b first_done", 32'(d1), 32'd4);
    check("b2b first_sum", 32'(r1), 32'h3333);
    check("b2b second_done", 32'(d2), 32'd9);
    check("b2b second_sum", 32'(sum_w[1]), 32'h1010);
    check("b2b done_pulses", 32'(dones), 32'd2);
    repeat (20) @(posedge clk);

    // Reset during the second RUN cycle aborts with no result.
    @(negedge clk);
    a = 16'h00F0; b = 16'h0F00; sub = 1'b0; c = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("abort c%0d sum", chunks[k]), 32'(sum_w[k]), 32'd0);
      check($sformatf("abort c%0d busy", chunks[k]), 32'(busy_w[k]), 32'd0);
      check($sformatf("abort c%0d done", chunks[k]), 32'(done_w[k]), 32'd0);
    end
    check("abort carry", 32'(carry_w[1]), 32'd0);
    check("abort ovf", 32'(ovf_w[1]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) if (done_w[k]) dones++;
    end
    check("abort no_done", 32'(dones), 32'd0);
    run_op(16'h00F0, 16'h0F00, 1'b0, 1'b1);
    check_op("after_reset", 16'h0FF1, 1'b0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rs = 1'($urandom); rc = 1'($urandom);
      m = model(ra, rb, rs, rc);
      run_op(ra, rb, rs, rc);
      check_op($sformatf("rand%0d", r), m[15:0], m[16], m[17]);
    end

    check("busy_done_overlap", 32'(overlap), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
